// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives the PC onto the bus, reads one memory word into ir,
// then strobes the PC increment. Misaligned addresses and memory timeouts park in FAULT.
module fetch_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  notReset,
    input  logic                  start,
    input  logic                  fault_ack,
    input  logic [DATA_WIDTH-1:0] pc_addr,
    output logic                  pc_notOE,
    output logic                  pc_inc,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_notRead,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    output logic                  busy,
    output logic                  fault
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StRead,
        StLatch,
        StFault
    } state_e;

    // Last READ cycle index before giving up on the memory.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [7:0]              wait_q, wait_d;
    logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   ir_q, ir_d;
    logic                    ir_valid_q, ir_valid_d;

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            mem_addr_q <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StAddr;
                    ir_valid_d = 1'b0;
                end
            end
            StAddr: begin
                mem_addr_d = pc_addr;
                state_d    = pc_addr[0] ? StFault : StRead;
            end
            StRead: begin
                // A ready on the timeout cycle still completes the fetch.
                if (mem_ready) begin
                    ir_d       = mem_data;
                    ir_valid_d = 1'b1;
                    state_d    = StLatch;
                end else if (wait_q == WaitLast) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StLatch: begin
                state_d = StIdle;
            end
            StFault: begin
                if (fault_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes come straight from the state register so reset deasserts them at once.
    assign pc_notOE    = (state_q != StAddr);
    assign mem_notRead = (state_q != StRead);
    assign pc_inc      = (state_q == StLatch);
    assign busy        = (state_q != StIdle);
    assign fault       = (state_q == StFault);
    assign mem_addr    = mem_addr_q;
    assign ir          = ir_q;
    assign ir_valid    = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: the driver pushes the predicted fetch outcome,
// the monitor pops it when the DUT pulses pc_inc or enters FAULT.
module tb_fetch_unit;

    localparam int unsigned DW = 16;
    localparam int unsigned TO = 15;

    logic          clock = 1'b0;
    logic          notReset = 1'b0;
    logic          start = 1'b0;
    logic          fault_ack = 1'b0;
    logic [DW-1:0] pc_addr = '0;
    logic          pc_notOE, pc_inc, mem_notRead, ir_valid, busy, fault;
    logic [DW-1:0] mem_addr, ir;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_data = '0;

    fetch_unit #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .notReset   (notReset),
        .start      (start),
        .fault_ack  (fault_ack),
        .pc_addr    (pc_addr),
        .pc_notOE   (pc_notOE),
        .pc_inc     (pc_inc),
        .mem_addr   (mem_addr),
        .mem_notRead(mem_notRead),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] addr;
        bit            ok;
        int            reads;
        logic [DW-1:0] ir_after;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_ir = '0;
    int            passed = 0;
    int            total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Reference: ready arrives after d idle READ cycles; TIMEOUT READ cycles are allowed.
    function automatic exp_t predict(input logic [DW-1:0] addr, input int d,
                                     input logic [DW-1:0] data);
        exp_t e;
        e.addr = addr;
        if (addr[0]) begin
            e.ok = 0; e.reads = 0;
        end else if (d < int'(TO)) begin
            e.ok = 1; e.reads = d + 1;
        end else begin
            e.ok = 0; e.reads = int'(TO);
        end
        if (e.ok) model_ir = data;
        e.ir_after = model_ir;
        return e;
    endfunction

    // Monitor
    exp_t cur;
    bit   in_txn = 0;
    bit   prev_fault = 0;
    int   reads = 0;
    int   bcnt = 0;

    always @(negedge clock) begin
        if (!notReset) begin
            in_txn     = 0;
            prev_fault = 0;
        end else begin
            check("oe_read_exclusive", {31'd0, pc_notOE | mem_notRead}, 32'd1);
            if (!pc_notOE) begin
                if (sb.size() == 0) begin
                    check("unexpected_fetch", 32'd1, 32'd0);
                end else begin
                    cur    = sb[0];
                    in_txn = 1;
                    reads  = 0;
                    bcnt   = 0;
                end
            end
            if (in_txn) begin
                if (busy) bcnt++;
                if (!mem_notRead) begin
                    reads++;
                    check("mem_addr_stable", 32'(mem_addr), 32'(cur.addr));
                end
            end
            if (pc_inc || (fault && !prev_fault)) begin
                if (!in_txn) begin
                    check("orphan_completion", 32'd1, 32'd0);
                end else begin
                    void'(sb.pop_front());
                    in_txn = 0;
                    check("outcome_ok", {31'd0, pc_inc}, {31'd0, cur.ok});
                    check("outcome_fault", {31'd0, fault}, {31'd0, !cur.ok});
                    check("ir", 32'(ir), 32'(cur.ir_after));
                    check("ir_valid", {31'd0, ir_valid}, {31'd0, cur.ok});
                    check("read_cycles", reads, cur.reads);
                    check("busy_cycles", bcnt, cur.reads + 2);
                    check("mem_addr", 32'(mem_addr), 32'(cur.addr));
                end
            end
            prev_fault = fault;
        end
    end

    task automatic fetch(input logic [DW-1:0] addr, input int d, input logic [DW-1:0] data);
        int rc = 0;
        int cyc = 0;
        sb.push_back(predict(addr, d, data));
        @(negedge clock);
        pc_addr = addr;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (cyc < 200 && busy && !fault) begin
            if (!mem_notRead) begin
                mem_ready = (rc == d);
                mem_data  = (rc == d) ? data : DW'($urandom);
                pc_addr   = DW'($urandom);
                fault_ack = 1'($urandom);
                rc++;
            end else begin
                mem_ready = 1'($urandom);
                mem_data  = DW'($urandom);
                fault_ack = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        mem_ready = 1'b0;
        fault_ack = 1'b0;
        if (cyc >= 200) check("fetch_bound", 32'd1, 32'd0);
        if (fault) begin
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clock);
            check("fault_holds", {31'd0, fault}, 32'd1);
            start     = 1'b0;
            fault_ack = 1'b1;
            @(negedge clock);
            fault_ack = 1'b0;
            check("ack_to_idle", {30'd0, busy, fault}, 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_fault"}, {31'd0, fault}, 32'd0);
        check({tag, "_strobes"}, {29'd0, pc_notOE, mem_notRead, pc_inc}, 32'd6);
        check({tag, "_ir"}, 32'(ir), 32'd0);
        check({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    endtask

    initial begin
        #1;
        check_reset_state("reset");
        @(negedge clock);
        notReset = 1'b1;

        fetch(16'h0010, 0, 16'hA5C3);
        fetch(16'h0020, 5, 16'h1234);
        fetch(16'h0030, 100, 16'hDEAD);
        fetch(16'h0011, 0, 16'hBEEF);
        fetch(16'h0040, int'(TO) - 1, 16'h5A5A);
        fetch(16'hFFFE, 0, 16'hC0DE);
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] a = DW'($urandom);
            int            d;
            if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
            fetch(a, d, DW'($urandom));
        end

        // Asynchronous reset in the middle of a long READ.
        sb.push_back(predict(16'h0050, 100, 16'h7777));
        @(negedge clock);
        pc_addr = 16'h0050;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_reset_in_read", {31'd0, mem_notRead}, 32'd0);
        #2 notReset = 1'b0;
        #1;
        check_reset_state("async_reset");
        sb.delete();
        model_ir = '0;
        @(negedge clock);
        notReset = 1'b1;
        @(negedge clock);
        check("post_reset_idle", {31'd0, busy}, 32'd0);
        fetch(16'h0060, 2, 16'h4321);

        repeat (2) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of address, data and instruction words.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum READ-state wait in cycles (1..255).
REQ-003 clock  input  1  SHALL be the single clock; all state changes on posedge.
REQ-004 notReset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request one instruction fetch; sampled only in IDLE.
REQ-006 fault_ack  input  1  SHALL clear FAULT; sampled only in FAULT.
REQ-007 pc_addr  input  DATA_WIDTH  SHALL carry the byte address driven by the program counter onto the bus.
REQ-008 pc_notOE  output  1  SHALL be the active-low output enable to the program counter.
REQ-009 pc_inc  output  1  SHALL be the active-high increment strobe to the program counter.
REQ-010 mem_addr  output  DATA_WIDTH  SHALL be the registered memory read address.
REQ-011 mem_notRead  output  1  SHALL be the active-low memory read strobe.
REQ-012 mem_ready  input  1  SHALL indicate mem_data is valid for the current read.
REQ-013 mem_data  input  DATA_WIDTH  SHALL carry the memory read data.
REQ-014 ir  output  DATA_WIDTH  SHALL hold the last fetched instruction word.
REQ-015 ir_valid  output  1  SHALL indicate ir holds a completed fetch.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.
REQ-017 fault  output  1  SHALL be high exactly while in FAULT.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, READ, LATCH, FAULT, with all outputs decoded from registered state (no input-to-output combinational path).
REQ-019 IDLE: start=1 at posedge SHALL go to ADDR and clear ir_valid; start=0 SHALL stay in IDLE.
REQ-020 ADDR (exactly 1 cycle): pc_notOE=0; at posedge mem_addr SHALL load pc_addr; next state READ if pc_addr[0]=0, FAULT if pc_addr[0]=1 (misaligned word address).
REQ-021 READ: mem_notRead=0 and the wait counter SHALL increment each cycle starting from 0.
REQ-022 READ with mem_ready=1 at posedge SHALL load ir from mem_data, set ir_valid and go to LATCH; minimum ADDR-to-ir latency is 2 cycles.
REQ-023 READ with mem_ready=0 when the counter equals TIMEOUT-1 SHALL go to FAULT with ir and ir_valid unchanged.
REQ-024 mem_ready=1 on the same edge as the timeout SHALL take priority (completes the fetch).
REQ-025 LATCH (exactly 1 cycle): pc_inc=1, then IDLE; pc_inc SHALL be high in no other state.
REQ-026 FAULT: fault_ack=1 at posedge SHALL go to IDLE; otherwise stay; start ignored.
REQ-027 pc_notOE and mem_notRead SHALL be high outside ADDR and READ respectively, and never both low in the same cycle.
REQ-028 start or fault_ack asserted in any state other than the one that samples it SHALL have no effect.
REQ-029 mem_addr SHALL be stable from the end of ADDR through the end of READ.
REQ-030 pc_addr = all-ones with bit0=0 (0xFFFE) SHALL fetch normally; increment wrap is the program counter's responsibility.

Reset
REQ-031 notReset=0 SHALL immediately, independent of clock, force IDLE, counter=0, ir=0, ir_valid=0, mem_addr=0, pc_notOE=1, mem_notRead=1, pc_inc=0, busy=0, fault=0.
REQ-032 Reset asserted mid-READ or mid-LATCH SHALL abort the fetch with no pc_inc pulse; release SHALL resume from IDLE on the first posedge with notReset=1.

Verification
REQ-033 Normal fetch: pc_addr=0x0010, start 1 cycle, mem_ready=1 in first READ cycle with mem_data=0xA5C3 -> mem_addr=0x0010, ir=0xA5C3, ir_valid=1, one pc_inc pulse, busy high exactly 3 cycles.
REQ-034 Wait states: mem_ready delayed 5 READ cycles -> mem_notRead low 6 cycles, mem_addr stable, single pc_inc after LATCH.
REQ-035 Timeout: TIMEOUT=15, mem_ready never -> FAULT after 15 READ cycles, fault=1, ir unchanged, no pc_inc; fault_ack -> IDLE next cycle.
REQ-036 Misaligned: pc_addr=0x0011 -> FAULT directly after ADDR, mem_notRead never low.
REQ-037 Timeout/ready tie: mem_ready=1 on 15th READ cycle -> fetch completes, fault stays 0.
REQ-038 Async reset mid-READ: notReset low between edges -> mem_notRead=1 and busy=0 before next posedge, ir=0, ir_valid=0.
